// File: rtl/hash_table_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hash_table (package)
//  Description : Shared widths and types for the hash-table head-pointer path.
//                head_upd_t is one head-pointer update command:
//                {bucket, ptr, ptr_val}.
//  Revision    : 1.0 - initial release
// ============================================================================
package hash_table;

    localparam int BUCKET_WIDTH   = 8;
    localparam int HEAD_PTR_WIDTH = 10;

    typedef struct packed {
        logic [BUCKET_WIDTH-1:0]   bucket;
        logic [HEAD_PTR_WIDTH-1:0] ptr;
        logic                      ptr_val;
    } head_upd_t;

    // Round-robin priority pointer for the two update clients.
    typedef enum logic {
        RR_INS = 1'b0,
        RR_DEL = 1'b1
    } rr_sel_e;

endpackage
`default_nettype wire

// File: rtl/head_table_if.sv
`default_nettype none
// ============================================================================
//  Module      : head_table_if
//  Description : Write port of the head-pointer RAM.
//                master : drives wr_addr, wr_data_ptr, wr_data_ptr_val, wr_en
//                slave  : RAM side, receives the same signals
//  Revision    : 1.0 - initial release
// ============================================================================
interface head_table_if;

    logic [hash_table::BUCKET_WIDTH-1:0]   wr_addr;
    logic [hash_table::HEAD_PTR_WIDTH-1:0] wr_data_ptr;
    logic                                  wr_data_ptr_val;
    logic                                  wr_en;

    modport master (
        output wr_addr,
        output wr_data_ptr,
        output wr_data_ptr_val,
        output wr_en
    );

    modport slave (
        input  wr_addr,
        input  wr_data_ptr,
        input  wr_data_ptr_val,
        input  wr_en
    );

endinterface
`default_nettype wire

// File: rtl/head_upd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : head_upd_fifo
//  Description : Synchronous show-ahead FIFO of head_upd_t commands.
//                i_clk/i_rst_n : clock, asynchronous active-low reset
//                i_push/i_push_data : write side (ignored when full)
//                i_pop  : drop head entry (ignored when empty)
//                o_head : current head entry (valid when !o_empty)
//                o_full/o_empty/o_count : occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module head_upd_fifo
    import hash_table::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  head_upd_t                    i_push_data,
    input  logic                         i_pop,
    output head_upd_t                    o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int c_CNT_W  = $clog2(DEPTH + 1);
    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    head_upd_t               r_mem [DEPTH];
    logic [c_ADDR_W-1:0]     r_wr_ptr;
    logic [c_ADDR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]      r_count;

    logic                    w_push;
    logic                    w_pop;

    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop  && !o_empty;

    // Storage is not reset: only entries between the pointers are ever read.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/head_table_writer.sv
`default_nettype none
// ============================================================================
//  Module      : head_table_writer
//  Description : Master of head_table_if. Round-robin arbitration of insert /
//                delete head-pointer updates into a command FIFO, drained one
//                RAM write per cycle, plus the head-RAM clear sequence
//                (IDLE -> DRAIN -> RUN -> WAIT -> IDLE).
//  Ports       : clk_i, rst_n_i            clock, async active-low reset
//                ins_* / del_*             valid/ready update clients
//                head_table_if             RAM write port (master)
//                clear_req_i               clear request (honoured in IDLE)
//                clear_ram_run_o           one-cycle RAM clear start
//                clear_ram_done_i          RAM clear finished
//                clear_done_o              one-cycle sequence complete
//                busy_o                    work pending or clear in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module head_table_writer
    import hash_table::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  head_upd_t           ins_upd_i,
    input  logic                ins_valid_i,
    output logic                ins_ready_o,
    input  head_upd_t           del_upd_i,
    input  logic                del_valid_i,
    output logic                del_ready_o,
    head_table_if.master        head_table_if,
    input  logic                clear_req_i,
    output logic                clear_ram_run_o,
    input  logic                clear_ram_done_i,
    output logic                clear_done_o,
    output logic                busy_o
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    rr_sel_e             r_rr;
    logic                r_wr_en;
    head_upd_t           r_wr;
    logic                r_clear_done;

    logic                w_grant_en;
    logic                w_gnt_ins;
    logic                w_gnt_del;
    logic                w_push;
    head_upd_t           w_push_data;
    logic                w_pop;
    head_upd_t           w_head;
    logic                w_full;
    logic                w_empty;
    logic [c_CNT_W-1:0]  w_count;

    // ------------------------------------------------------------------------
    // Arbiter. rst_n_i gates the grant so no ready is ever seen during reset.
    // A clear request blocks grants in the same cycle it is raised, and the
    // full flag does not credit a simultaneous pop.
    // ------------------------------------------------------------------------
    assign w_grant_en  = rst_n_i && (r_state == S_IDLE) && !w_full && !clear_req_i;
    assign w_gnt_ins   = w_grant_en && ins_valid_i && (!del_valid_i || (r_rr == RR_INS));
    assign w_gnt_del   = w_grant_en && del_valid_i && (!ins_valid_i || (r_rr == RR_DEL));

    assign ins_ready_o = w_gnt_ins;
    assign del_ready_o = w_gnt_del;

    assign w_push      = w_gnt_ins || w_gnt_del;
    assign w_push_data = w_gnt_ins ? ins_upd_i : del_upd_i;

    // The pointer always moves to the client that was not just served.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rr <= RR_INS;
        end else if (w_gnt_ins) begin
            r_rr <= RR_DEL;
        end else if (w_gnt_del) begin
            r_rr <= RR_INS;
        end
    end

    head_upd_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (clk_i),
        .i_rst_n     (rst_n_i),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    // ------------------------------------------------------------------------
    // Drain: pops are frozen once the RAM clear has started.
    // ------------------------------------------------------------------------
    assign w_pop = !w_empty && ((r_state == S_IDLE) || (r_state == S_DRAIN));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_en <= 1'b0;
            r_wr    <= '0;
        end else begin
            r_wr_en <= w_pop;
            if (w_pop) begin
                r_wr <= w_head;
            end
        end
    end

    assign head_table_if.wr_en           = r_wr_en;
    assign head_table_if.wr_addr         = r_wr.bucket;
    assign head_table_if.wr_data_ptr     = r_wr.ptr;
    assign head_table_if.wr_data_ptr_val = r_wr.ptr_val;

    // ------------------------------------------------------------------------
    // Clear sequencer. DRAIN exits only after the last write has left the
    // output register, so the run pulse never overlaps a RAM write.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clear_req_i)           w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_empty && !r_wr_en)   w_state_nxt = S_RUN;
            S_RUN:                              w_state_nxt = S_WAIT;
            S_WAIT:  if (clear_ram_done_i)      w_state_nxt = S_IDLE;
            default:                            w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= S_IDLE;
            r_clear_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_clear_done <= (r_state == S_WAIT) && clear_ram_done_i;
        end
    end

    assign clear_ram_run_o = (r_state == S_RUN);
    assign clear_done_o    = r_clear_done;
    assign busy_o          = (w_count != '0) || r_wr_en || (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_head_table_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_head_table_writer
//  Description : Self-checking bench for head_table_writer. A cycle model of
//                the arbiter, FIFO, write register and clear sequencer keeps
//                a scoreboard queue of accepted commands that is popped when
//                a RAM write is due; every cycle the DUT is compared with it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_head_table_writer;
    import hash_table::*;

    localparam int DEPTH   = 4;
    localparam int M_IDLE  = 0;
    localparam int M_DRAIN = 1;
    localparam int M_RUN   = 2;
    localparam int M_WAIT  = 3;

    logic      clk_i   = 1'b0;
    logic      rst_n_i = 1'b0;
    head_upd_t ins_upd_i;
    logic      ins_valid_i;
    logic      ins_ready_o;
    head_upd_t del_upd_i;
    logic      del_valid_i;
    logic      del_ready_o;
    logic      clear_req_i;
    logic      clear_ram_run_o;
    logic      clear_ram_done_i;
    logic      clear_done_o;
    logic      busy_o;

    head_table_if u_ht_if ();

    head_table_writer #(
        .FIFO_DEPTH       (DEPTH)
    ) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .ins_upd_i        (ins_upd_i),
        .ins_valid_i      (ins_valid_i),
        .ins_ready_o      (ins_ready_o),
        .del_upd_i        (del_upd_i),
        .del_valid_i      (del_valid_i),
        .del_ready_o      (del_ready_o),
        .head_table_if    (u_ht_if),
        .clear_req_i      (clear_req_i),
        .clear_ram_run_o  (clear_ram_run_o),
        .clear_ram_done_i (clear_ram_done_i),
        .clear_done_o     (clear_done_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ------------------------------------------------------------------------
    // Reference model + scoreboard, evaluated at the falling edge (inputs are
    // stable there until the next rising edge).
    // ------------------------------------------------------------------------
    head_upd_t   m_q[$];
    int          m_rr;
    int          m_st;
    logic        m_wr_en;
    head_upd_t   m_wr;
    logic        m_done;
    int          run_cnt = 0;
    logic [7:0]  wr_log[$];
    logic        acc_ins = 1'b0;
    logic        acc_del = 1'b0;

    always @(negedge clk_i) begin : mon
        logic en, e_ins, e_del, pop, drained;
        if (!rst_n_i) begin
            m_q.delete();
            m_rr    = 0;
            m_st    = M_IDLE;
            m_wr_en = 1'b0;
            m_wr    = '0;
            m_done  = 1'b0;
        end
        en    = rst_n_i && (m_st == M_IDLE) && (m_q.size() < DEPTH) && !clear_req_i;
        e_ins = en && ins_valid_i && (!del_valid_i || m_rr == 0);
        e_del = en && del_valid_i && (!ins_valid_i || m_rr == 1);

        check("ins_ready",   32'(ins_ready_o),              32'(e_ins));
        check("del_ready",   32'(del_ready_o),              32'(e_del));
        check("wr_en",       32'(u_ht_if.wr_en),            32'(m_wr_en));
        check("wr_addr",     32'(u_ht_if.wr_addr),          32'(m_wr.bucket));
        check("wr_ptr",      32'(u_ht_if.wr_data_ptr),      32'(m_wr.ptr));
        check("wr_ptr_val",  32'(u_ht_if.wr_data_ptr_val),  32'(m_wr.ptr_val));
        check("clear_run",   32'(clear_ram_run_o),          32'(m_st == M_RUN));
        check("clear_done",  32'(clear_done_o),             32'(m_done));
        check("busy",        32'(busy_o),
              32'((m_q.size() != 0) || m_wr_en || (m_st != M_IDLE)));

        if (clear_ram_run_o)  run_cnt++;
        if (u_ht_if.wr_en)    wr_log.push_back(u_ht_if.wr_addr);
        acc_ins = ins_valid_i && ins_ready_o;
        acc_del = del_valid_i && del_ready_o;

        if (rst_n_i) begin
            drained = (m_q.size() == 0) && !m_wr_en;
            m_done  = (m_st == M_WAIT) && clear_ram_done_i;
            pop     = (m_q.size() > 0) && (m_st == M_IDLE || m_st == M_DRAIN);
            m_wr_en = pop;
            if (pop) m_wr = m_q.pop_front();
            if (e_ins) begin
                m_q.push_back(ins_upd_i);
                m_rr = 1;
            end else if (e_del) begin
                m_q.push_back(del_upd_i);
                m_rr = 0;
            end
            case (m_st)
                M_IDLE:  if (clear_req_i)      m_st = M_DRAIN;
                M_DRAIN: if (drained)          m_st = M_RUN;
                M_RUN:                         m_st = M_WAIT;
                default: if (clear_ram_done_i) m_st = M_IDLE;
            endcase
        end
    end

    // Advance one cycle; each client moves to a new bucket after an accept.
    task automatic adv();
        @(posedge clk_i);
        #1;
        if (acc_ins) ins_upd_i.bucket = ins_upd_i.bucket + 8'd1;
        if (acc_del) del_upd_i.bucket = del_upd_i.bucket + 8'd1;
    endtask

    initial begin : stim
        int base;
        ins_upd_i        = '{bucket: 8'h10, ptr: 10'h001, ptr_val: 1'b1};
        del_upd_i        = '{bucket: 8'h20, ptr: 10'h2A5, ptr_val: 1'b0};
        ins_valid_i      = 1'b1;
        del_valid_i      = 1'b1;
        clear_req_i      = 1'b0;
        clear_ram_done_i = 1'b0;

        // Reset held with both clients requesting.
        repeat (3) adv();
        check("rst_ins_ready", 32'(ins_ready_o),   32'd0);
        check("rst_del_ready", 32'(del_ready_o),   32'd0);
        check("rst_wr_en",     32'(u_ht_if.wr_en), 32'd0);
        check("rst_wr_addr",   32'(u_ht_if.wr_addr), 32'd0);
        check("rst_busy",      32'(busy_o),        32'd0);
        rst_n_i = 1'b1;
        #1;
        check("first_grant_ins", 32'(ins_ready_o), 32'd1);
        check("first_grant_del", 32'(del_ready_o), 32'd0);

        // Both clients continuously valid: writes alternate insert/delete.
        wr_log.delete();
        repeat (10) adv();
        ins_valid_i = 1'b0;
        del_valid_i = 1'b0;
        repeat (4) adv();
        check("alt_count", 32'(wr_log.size()), 32'd10);
        if (wr_log.size() >= 4) begin
            check("alt_w0", 32'(wr_log[0]), 32'h10);
            check("alt_w1", 32'(wr_log[1]), 32'h20);
            check("alt_w2", 32'(wr_log[2]), 32'h11);
            check("alt_w3", 32'(wr_log[3]), 32'h21);
        end

        // Fill burst: six cycles of dual traffic, nothing lost or duplicated.
        ins_upd_i.bucket = 8'h30;
        del_upd_i.bucket = 8'h40;
        base = wr_log.size();
        ins_valid_i = 1'b1;
        del_valid_i = 1'b1;
        repeat (6) adv();
        ins_valid_i = 1'b0;
        del_valid_i = 1'b0;
        repeat (4) adv();
        check("fill_count", 32'(wr_log.size() - base), 32'd6);

        // Clear with pending writes; clients keep requesting throughout.
        run_cnt = 0;
        ins_valid_i = 1'b1;
        del_valid_i = 1'b1;
        repeat (3) adv();
        clear_req_i = 1'b1;
        adv();
        clear_req_i = 1'b0;
        for (int i = 0; i < 20 && run_cnt == 0; i++) adv();
        check("clr_run_seen", 32'(run_cnt), 32'd1);
        repeat (10) adv();
        clear_ram_done_i = 1'b1;
        adv();
        clear_ram_done_i = 1'b0;
        check("clr_done_pulse", 32'(clear_done_o), 32'd1);
        check("clr_ready_back", 32'(ins_ready_o || del_ready_o), 32'd1);
        ins_valid_i = 1'b0;
        del_valid_i = 1'b0;
        repeat (4) adv();

        // A second clear request while waiting must be ignored.
        run_cnt = 0;
        clear_req_i = 1'b1;
        adv();
        clear_req_i = 1'b0;
        for (int i = 0; i < 20 && run_cnt == 0; i++) adv();
        adv();
        clear_req_i = 1'b1;
        adv();
        clear_req_i = 1'b0;
        repeat (8) adv();
        clear_ram_done_i = 1'b1;
        adv();
        clear_ram_done_i = 1'b0;
        repeat (6) adv();
        check("wait_req_runs", 32'(run_cnt), 32'd1);

        // Reset during DRAIN discards the pending clear and the queued work.
        run_cnt = 0;
        ins_valid_i = 1'b1;
        adv();
        ins_valid_i = 1'b0;
        clear_req_i = 1'b1;
        adv();
        clear_req_i = 1'b0;
        rst_n_i = 1'b0;
        repeat (2) adv();
        rst_n_i = 1'b1;
        repeat (10) adv();
        check("rst_drain_runs",  32'(run_cnt),       32'd0);
        check("rst_drain_busy",  32'(busy_o),        32'd0);
        check("rst_drain_wr_en", 32'(u_ht_if.wr_en), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
